// File: rtl/sdf4_lane_serializer.sv
// sdf4_lane_serializer: collects 4-lane SDF frames into a ping-pong buffer and replays them serially in natural order.
// Define SDF4_SER_INDEX_EN to add the output_index port (sample index registered alongside each sample).
module sdf4_lane_serializer #(
    parameter int WIDTH          = 32,
    parameter int Num_of_samples = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             input_en,
    input  logic [WIDTH-1:0] input_real_0,
    input  logic [WIDTH-1:0] input_real_1,
    input  logic [WIDTH-1:0] input_real_2,
    input  logic [WIDTH-1:0] input_real_3,
    input  logic [WIDTH-1:0] input_imag_0,
    input  logic [WIDTH-1:0] input_imag_1,
    input  logic [WIDTH-1:0] input_imag_2,
    input  logic [WIDTH-1:0] input_imag_3,
    output logic             output_en,
    output logic [WIDTH-1:0] output_real,
    output logic [WIDTH-1:0] output_imag,
    output logic             frame_start,
    output logic             overflow
`ifdef SDF4_SER_INDEX_EN
    ,
    output logic [$clog2(Num_of_samples)-1:0] output_index
`endif
);
    localparam int N  = Num_of_samples;
    localparam int Q  = N / 4;
    localparam int AW = $clog2(N);
    localparam int QW = (Q > 1) ? $clog2(Q) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    logic [2*WIDTH-1:0] r_mem [2][N];
    logic [QW-1:0]      r_wcnt;
    logic               r_wbank;
    logic               r_rbank;
    logic [1:0]         r_full;
    state_t             r_state;
    logic [AW-1:0]      r_rcnt;

    logic [2*WIDTH-1:0] w_lane [4];
    logic               w_wr;
    logic               w_wlast;
    logic               w_cont;
    logic               w_start;
    logic               w_clr;
    logic [AW-1:0]      w_idx;
    logic [2*WIDTH-1:0] w_rd;
    logic [1:0]         w_set_v;
    logic [1:0]         w_clr_v;

    assign w_lane[0] = {input_real_0, input_imag_0};
    assign w_lane[1] = {input_real_1, input_imag_1};
    assign w_lane[2] = {input_real_2, input_imag_2};
    assign w_lane[3] = {input_real_3, input_imag_3};

    assign w_wr    = input_en && !r_full[r_wbank];
    assign w_wlast = r_wcnt == QW'(Q - 1);
    // w_cont: mid-frame; otherwise the reader may start a frame from rbank this edge
    assign w_cont  = (r_state == RUN) && (r_rcnt != AW'(N - 1));
    assign w_start = !w_cont && r_full[r_rbank];
    assign w_idx   = w_cont ? r_rcnt + 1'b1 : '0;
    assign w_rd    = r_mem[r_rbank][w_idx];
    // the bank is released on the edge that registers its last sample
    assign w_clr   = w_cont && (r_rcnt == AW'(N - 2));
    assign w_set_v = (w_wr && w_wlast) ? (2'b01 << r_wbank) : 2'b00;
    assign w_clr_v = w_clr ? (2'b01 << r_rbank) : 2'b00;

    always_ff @(posedge clock) begin
        if (w_wr)
            for (int j = 0; j < 4; j++)
                r_mem[r_wbank][AW'(j * Q) + AW'(r_wcnt)] <= w_lane[j];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wcnt      <= '0;
            r_wbank     <= 1'b0;
            r_rbank     <= 1'b0;
            r_full      <= 2'b00;
            r_state     <= IDLE;
            r_rcnt      <= '0;
            output_en   <= 1'b0;
            frame_start <= 1'b0;
            overflow    <= 1'b0;
            output_real <= '0;
            output_imag <= '0;
        end else begin
            if (w_wr) begin
                r_wcnt <= w_wlast ? '0 : r_wcnt + 1'b1;
                if (w_wlast)
                    r_wbank <= ~r_wbank;
            end
            if (input_en && r_full[r_wbank])
                overflow <= 1'b1;
            r_full <= (r_full | w_set_v) & ~w_clr_v;
            if (w_clr)
                r_rbank <= ~r_rbank;
            if (w_cont || w_start) begin
                r_state     <= RUN;
                output_en   <= 1'b1;
                frame_start <= !w_cont;
                r_rcnt      <= w_idx;
                output_real <= w_rd[2*WIDTH-1:WIDTH];
                output_imag <= w_rd[WIDTH-1:0];
            end else begin
                r_state     <= IDLE;
                output_en   <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

`ifdef SDF4_SER_INDEX_EN
    assign output_index = r_rcnt;
`endif
endmodule
